// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell, a registered borrow, and a start/busy/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bor,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic             zacc;

   logic             load;
   logic             last;
   logic             ai;
   logic             bi;
   logic             d;
   logic             brw_n;

   // Full-subtractor cell working on the current LSBs of the operand shift registers
   assign ai    = a_sr[0];
   assign bi    = b_sr[0];
   assign d     = ai ^ bi ^ brw;
   assign brw_n = (~ai & bi) | (~(ai ^ bi) & brw);

   assign busy = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      last    = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Result flags are only written on the final bit so they hold across a whole run
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         brw    <= 1'b0;
         zacc   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bor    <= 1'b0;
         zero   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (load) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
            zacc <= 1'b0;
         end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d, res_sr[WIDTH-1:1]};
            brw    <= brw_n;
            cnt    <= cnt + CW'(1);
            zacc   <= zacc | d;
            if (last) begin
               diff <= {d, res_sr[WIDTH-1:1]};
               bor  <= brw_n;
               zero <= ~(zacc | d);
               ovf  <= (ai ^ bi) & (ai ^ d);
               done <= 1'b1;
            end
         end
      end
   end

endmodule
